turn_signal_seq: RTL
====================

Name: turn_signal_seq

Overview:
- Parametrised successor to the lab tail-light controller: sequential (thermometer) turn-signal lamps per side, a hazard mode and a brake overlay.
- Built-in step prescaler, so lamp pacing is independent of the clock rate.
- Sits between the stick/brake input synchroniser and the lamp drivers.
- All state is registered; lamp outputs are decoded only from registers.

Parameters:
- LAMPS_PER_SIDE, 3, lamps per side (legal 1..8); bit 0 = innermost lamp.
- TICK_DIV, 4, clock cycles per sequence step (legal >=1); prescaler width = max(1, clog2(TICK_DIV)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high.
- stick  in  2  0=off, 1=right, 2=left, 3=hazard.
- brake  in  1  brake pedal, level.
- left_lamps  out  LAMPS_PER_SIDE  left lamp drive, bit 0 inner.
- right_lamps  out  LAMPS_PER_SIDE  right lamp drive, bit 0 inner.
- busy  out  1  high when mode != IDLE.
- wrap  out  1  one-cycle pulse: sequence or hazard period completed.

Behaviour:
- Registers:
  - mode: IDLE/RIGHT/LEFT/HAZARD, encoded 0/1/2/3 to match stick.
  - k: 0..LAMPS_PER_SIDE.
  - cnt: prescaler.
  - phase: hazard on/off.
  - brake_q.
  - wrap_q.
- Reset: mode=IDLE, k=0, cnt=0, phase=0, brake_q=0, wrap_q=0, giving lamps=0, busy=0, wrap=0. Reset takes priority over every other event, including mid-sequence.
- Every edge: brake_q <= brake (1-cycle brake latency).
- Mode change (stick != mode): mode <= stick; k, cnt, phase <= 0; wrap_q <= 0. Takes priority over the step logic in that cycle. Lamps show the new mode's step 0 on the following cycle.
- Same mode, mode == IDLE: cnt, k, phase held at 0; wrap_q <= 0.
- Same mode, mode != IDLE:
  - If cnt == TICK_DIV-1: cnt <= 0 and a step occurs.
  - Else: cnt <= cnt+1, no step.
  - With TICK_DIV=1, a step occurs every cycle.
- Step in RIGHT/LEFT:
  - k <= (k == LAMPS_PER_SIDE) ? 0 : k+1.
  - wrap_q <= 1 only when k wraps LAMPS_PER_SIDE->0.
- Step in HAZARD:
  - phase <= ~phase.
  - wrap_q <= 1 only on the 1->0 transition.
- wrap_q is 0 in every cycle without a qualifying step. wrap = wrap_q, so it is high for exactly one cycle.
- Timing:
  - The first step lands TICK_DIV cycles after mode entry.
  - Signal period = (LAMPS_PER_SIDE+1)*TICK_DIV cycles.
  - Hazard period = 2*TICK_DIV cycles.
- Lamp decode (ALL = all ones, THERM(k) = low k bits set):
  - IDLE: left = right = brake_q ? ALL : 0.
  - RIGHT: right = THERM(k); left = brake_q ? ALL : 0.
  - LEFT: left = THERM(k); right = brake_q ? ALL : 0.
  - HAZARD: left = right = phase ? ALL : 0; brake ignored.
- busy = (mode != IDLE), from the register.
- Direct RIGHT<->LEFT or signal<->HAZARD changes restart from k=0 / phase=0; there is no partial carry-over.
- The stick value 3 is a real mode, not don't-care. No latches; every output is defined in every state.

Test Plan (LAMPS_PER_SIDE=3, TICK_DIV=4):
- Reset, then stick=1 held: right_lamps = 000 for 4 cycles, then 001, 011, 111, 000 for 4 cycles each; wrap pulses once on the 111->000 edge; left_lamps=000; busy=1 after the first edge.
- stick=2 held 40 cycles: the left sequence repeats with period 16; wrap is high exactly once per 16 cycles; right_lamps=000 throughout.
- stick=3: both sides 000 for 4 cycles, then 111 for 4, alternating; wrap pulses every 8 cycles; asserting brake leaves the pattern unchanged.
- stick=1 with brake=1: left_lamps=111 from the cycle after brake is registered, while right continues THERM(k); brake=0 clears left one cycle later. In IDLE, brake=1 drives both sides to 111.
- stick 1->2 while right_lamps=011: next cycle right=000 and left=000 (k=0), with left=001 4 cycles later; wrap is not asserted.
- reset=1 while left=111 in LEFT: next edge gives all outputs 0 and busy=0; with stick still 2 after reset drops, the sequence restarts from 000.

Source files
------------

// File: rtl/turn_signal_seq.sv
// -----------------------------------------------------------------------------
// turn_signal_seq
//
// Sequential (thermometer) turn-signal controller with hazard mode and a brake
// overlay. A built-in prescaler paces the lamp sequence in units of TICK_DIV
// clock cycles, so the visible step rate does not depend on the clock rate.
// All state lives in registers, and the lamp outputs are decoded only from
// those registers.
//
// Parameters:
//   LAMPS_PER_SIDE  lamps per side (1..8), bit 0 is the innermost lamp
//   TICK_DIV        clock cycles per sequence step (>= 1)
//
// Ports:
//   clk          in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset, clears all state
//   stick  [1:0] in   0 = off, 1 = right, 2 = left, 3 = hazard
//   brake        in   brake pedal level
//   left_lamps   out  left lamp drive, bit 0 inner
//   right_lamps  out  right lamp drive, bit 0 inner
//   busy         out  high whenever the registered mode is not IDLE
//   wrap         out  one-cycle pulse when a signal sequence or a hazard
//                     period completes
// -----------------------------------------------------------------------------
module turn_signal_seq #(
  parameter int LAMPS_PER_SIDE = 3,
  parameter int TICK_DIV       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                stick,
  input  logic                      brake,
  output logic [LAMPS_PER_SIDE-1:0] left_lamps,
  output logic [LAMPS_PER_SIDE-1:0] right_lamps,
  output logic                      busy,
  output logic                      wrap
);

  // Prescaler width: at least one bit even when TICK_DIV is 1, so the
  // counter register always exists and simply stays at its terminal value.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // The step index k runs 0..LAMPS_PER_SIDE inclusive, one more value than
  // there are lamps, because the all-dark step 0 is part of the sequence.
  localparam int K_W = $clog2(LAMPS_PER_SIDE + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(LAMPS_PER_SIDE);

  localparam logic [LAMPS_PER_SIDE-1:0] ALL_ON  = {LAMPS_PER_SIDE{1'b1}};
  localparam logic [LAMPS_PER_SIDE-1:0] ALL_OFF = '0;

  // Mode encoding deliberately equals the stick code, so a mode change is a
  // plain comparison and the new mode is the stick value itself.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RIGHT  = 2'd1,
    LEFT   = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  mode_t            mode;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             brake_q;
  logic             wrap_q;

  mode_t            stick_mode;
  logic             step;
  logic [LAMPS_PER_SIDE-1:0] therm;

  assign stick_mode = mode_t'(stick);

  // A step fires on the last prescaler count; only meaningful while the
  // mode is stable and active, which the sequential block takes care of.
  assign step = (cnt == CNT_LAST);

  // Sequencer state. A stick change restarts the new mode from step 0 and
  // wins over any step that would have happened on the same edge, so a
  // direct RIGHT<->LEFT or signal<->HAZARD change never carries progress
  // over and never produces a wrap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= IDLE;
      k       <= '0;
      cnt     <= '0;
      phase   <= 1'b0;
      brake_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      brake_q <= brake;
      wrap_q  <= 1'b0;

      if (stick_mode != mode) begin
        mode  <= stick_mode;
        k     <= '0;
        cnt   <= '0;
        phase <= 1'b0;
      end else if (mode == IDLE) begin
        k     <= '0;
        cnt   <= '0;
        phase <= 1'b0;
      end else if (!step) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
        if (mode == HAZARD) begin
          phase <= ~phase;
          // A hazard period ends when the lamps go from lit back to dark.
          if (phase) begin
            wrap_q <= 1'b1;
          end
        end else begin
          if (k == K_LAST) begin
            k      <= '0;
            wrap_q <= 1'b1;
          end else begin
            k <= k + K_W'(1);
          end
        end
      end
    end
  end

  // Thermometer code of k: the k innermost lamps lit.
  always_comb begin
    therm = '0;
    for (int i = 0; i < LAMPS_PER_SIDE; i++) begin
      therm[i] = (K_W'(i) < k);
    end
  end

  // Lamp decode from registered state only. The brake overlay lights the
  // side that is not signalling; hazard ignores the brake entirely so the
  // flashing pattern stays recognisable.
  always_comb begin
    left_lamps  = ALL_OFF;
    right_lamps = ALL_OFF;
    unique case (mode)
      IDLE: begin
        left_lamps  = brake_q ? ALL_ON : ALL_OFF;
        right_lamps = brake_q ? ALL_ON : ALL_OFF;
      end
      RIGHT: begin
        left_lamps  = brake_q ? ALL_ON : ALL_OFF;
        right_lamps = therm;
      end
      LEFT: begin
        left_lamps  = therm;
        right_lamps = brake_q ? ALL_ON : ALL_OFF;
      end
      HAZARD: begin
        left_lamps  = phase ? ALL_ON : ALL_OFF;
        right_lamps = phase ? ALL_ON : ALL_OFF;
      end
      default: begin
        left_lamps  = ALL_OFF;
        right_lamps = ALL_OFF;
      end
    endcase
  end

  assign busy = (mode != IDLE);
  assign wrap = wrap_q;

endmodule
